// File: rtl/hcpf_axi_mem_slave.sv
// BRAM-backed responder for the HCPF reduced AXI4 master port (64-bit INCR, ID 1, no strobes).
// Optional HCPF_SLAVE_BEAT_CNT_EN enables the wr_beats/rd_beats handshake counters.
module hcpf_axi_mem_slave #(
  parameter int          MEM_WORDS_LOG2 = 10,
  parameter logic [5:0]  RID_VALUE      = 6'd1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        aw_valid,
  output logic        aw_ready,
  input  logic [31:0] aw_bits_addr,
  input  logic [7:0]  aw_bits_len,
  input  logic        w_valid,
  output logic        w_ready,
  input  logic [63:0] w_bits_data,
  input  logic        w_bits_last,
  output logic        b_valid,
  input  logic        b_ready,
  input  logic        ar_valid,
  output logic        ar_ready,
  input  logic [31:0] ar_bits_addr,
  input  logic [7:0]  ar_bits_len,
  output logic        r_valid,
  input  logic        r_ready,
  output logic [63:0] r_bits_data,
  output logic        r_bits_last,
  output logic [5:0]  r_bits_id,
  output logic        proto_err,
  output logic [31:0] wr_beats,
  output logic [31:0] rd_beats
);

  localparam int MEM_WORDS = 1 << MEM_WORDS_LOG2;
  localparam logic [MEM_WORDS_LOG2-1:0] IDX_ONE = {{(MEM_WORDS_LOG2-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, WRITE, WRESP, READ} state_t;

  state_t                    state;
  logic [63:0]               mem [0:MEM_WORDS-1];
  logic [MEM_WORDS_LOG2-1:0] wr_idx;
  logic [MEM_WORDS_LOG2-1:0] rd_idx;
  logic [7:0]                wr_len;
  logic [7:0]                wr_beat;
  logic [7:0]                rd_len;
  logic [7:0]                rd_beat;
  logic                      rr_wr;
  logic                      sel_wr;
  logic                      sel_rd;
  logic                      aw_acc;
  logic                      ar_acc;
  logic                      w_hs;
  logic                      r_hs;
  logic                      unused_addr_bits;

  function automatic logic [MEM_WORDS_LOG2-1:0] word_index(input logic [31:0] addr);
    return addr[MEM_WORDS_LOG2+2:3];
  endfunction

  // Round-robin only matters when both requests are pending together.
  always_comb begin
    sel_wr = aw_valid && (!ar_valid || rr_wr);
    sel_rd = ar_valid && (!aw_valid || !rr_wr);
  end

  assign aw_acc    = aw_valid && aw_ready;
  assign ar_acc    = ar_valid && ar_ready;
  assign w_hs      = w_valid && w_ready;
  assign r_hs      = r_valid && r_ready;
  assign r_bits_id = RID_VALUE;

  assign unused_addr_bits = ^{aw_bits_addr[31:MEM_WORDS_LOG2+3], aw_bits_addr[2:0],
                              ar_bits_addr[31:MEM_WORDS_LOG2+3], ar_bits_addr[2:0]};

  // Memory write port; contents survive reset.
  always_ff @(posedge clock) begin
    if (w_hs)
      mem[wr_idx] <= w_bits_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      aw_ready    <= 1'b0;
      ar_ready    <= 1'b0;
      w_ready     <= 1'b0;
      b_valid     <= 1'b0;
      r_valid     <= 1'b0;
      r_bits_last <= 1'b0;
      r_bits_data <= 64'd0;
      proto_err   <= 1'b0;
      rr_wr       <= 1'b1;
      wr_idx      <= '0;
      rd_idx      <= '0;
      wr_len      <= 8'd0;
      wr_beat     <= 8'd0;
      rd_len      <= 8'd0;
      rd_beat     <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (aw_acc) begin
            state    <= WRITE;
            wr_idx   <= word_index(aw_bits_addr);
            wr_len   <= aw_bits_len;
            wr_beat  <= 8'd0;
            aw_ready <= 1'b0;
            ar_ready <= 1'b0;
            w_ready  <= 1'b1;
            rr_wr    <= 1'b0;
          end else if (ar_acc) begin
            state    <= READ;
            rd_idx   <= word_index(ar_bits_addr);
            rd_len   <= ar_bits_len;
            rd_beat  <= 8'd0;
            aw_ready <= 1'b0;
            ar_ready <= 1'b0;
            rr_wr    <= 1'b1;
          end else begin
            aw_ready <= sel_wr;
            ar_ready <= sel_rd;
          end
        end

        // Burst length is governed by w_bits_last; len only drives the error check.
        WRITE: begin
          if (w_hs) begin
            wr_idx  <= wr_idx + IDX_ONE;
            wr_beat <= wr_beat + 8'd1;
            if (w_bits_last) begin
              if (wr_beat != wr_len)
                proto_err <= 1'b1;
              w_ready <= 1'b0;
              b_valid <= 1'b1;
              state   <= WRESP;
            end else if (wr_beat == wr_len) begin
              proto_err <= 1'b1;
            end
          end
        end

        WRESP: begin
          if (b_valid && b_ready) begin
            b_valid  <= 1'b0;
            state    <= IDLE;
            aw_ready <= sel_wr;
            ar_ready <= sel_rd;
          end
        end

        // Alternates fetch cycle (r_valid low) and hold-until-accept cycle.
        READ: begin
          if (!r_valid) begin
            r_bits_data <= mem[rd_idx];
            r_bits_last <= (rd_beat == rd_len);
            r_valid     <= 1'b1;
            rd_idx      <= rd_idx + IDX_ONE;
          end else if (r_hs) begin
            r_valid     <= 1'b0;
            r_bits_last <= 1'b0;
            if (r_bits_last) begin
              state    <= IDLE;
              aw_ready <= sel_wr;
              ar_ready <= sel_rd;
            end else begin
              rd_beat <= rd_beat + 8'd1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef HCPF_SLAVE_BEAT_CNT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_beats <= 32'd0;
      rd_beats <= 32'd0;
    end else begin
      if (w_hs)
        wr_beats <= wr_beats + 32'd1;
      if (r_hs)
        rd_beats <= rd_beats + 32'd1;
    end
  end
`else
  assign wr_beats = 32'd0;
  assign rd_beats = 32'd0;
`endif

endmodule

// File: tb/tb_hcpf_axi_mem_slave.sv
// Directed self-checking bench for hcpf_axi_mem_slave.
module tb_hcpf_axi_mem_slave;

  logic        clock;
  logic        reset_n;
  logic        aw_valid, aw_ready;
  logic [31:0] aw_bits_addr;
  logic [7:0]  aw_bits_len;
  logic        w_valid, w_ready;
  logic [63:0] w_bits_data;
  logic        w_bits_last;
  logic        b_valid, b_ready;
  logic        ar_valid, ar_ready;
  logic [31:0] ar_bits_addr;
  logic [7:0]  ar_bits_len;
  logic        r_valid, r_ready;
  logic [63:0] r_bits_data;
  logic        r_bits_last;
  logic [5:0]  r_bits_id;
  logic        proto_err;
  logic [31:0] wr_beats, rd_beats;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] wd    [0:7];
  logic [63:0] rdata [0:7];
  logic        rlast [0:7];
  logic [5:0]  rid_obs;

  hcpf_axi_mem_slave #(.MEM_WORDS_LOG2(10), .RID_VALUE(6'd1)) dut (
    .clock(clock), .reset_n(reset_n),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_bits_addr(aw_bits_addr), .aw_bits_len(aw_bits_len),
    .w_valid(w_valid), .w_ready(w_ready), .w_bits_data(w_bits_data), .w_bits_last(w_bits_last),
    .b_valid(b_valid), .b_ready(b_ready),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_bits_addr(ar_bits_addr), .ar_bits_len(ar_bits_len),
    .r_valid(r_valid), .r_ready(r_ready), .r_bits_data(r_bits_data), .r_bits_last(r_bits_last),
    .r_bits_id(r_bits_id), .proto_err(proto_err), .wr_beats(wr_beats), .rd_beats(rd_beats)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset;
    reset_n = 1'b0;
    tick;
    tick;
    reset_n = 1'b1;
    tick;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input int nbeats,
                           input int last_at, output logic wr_first, output logic b_prompt,
                           output logic tout);
    int n;
    tout = 1'b0;
    aw_valid = 1'b1; aw_bits_addr = addr; aw_bits_len = len;
    n = 0;
    while (!aw_ready && n < 20) begin tick; n++; end
    if (!aw_ready) tout = 1'b1;
    tick;
    aw_valid = 1'b0;
    wr_first = w_ready;
    for (int i = 0; i < nbeats; i++) begin
      w_valid = 1'b1; w_bits_data = wd[i]; w_bits_last = (i == last_at);
      n = 0;
      while (!w_ready && n < 20) begin tick; n++; end
      if (!w_ready) tout = 1'b1;
      tick;
    end
    w_valid = 1'b0; w_bits_last = 1'b0;
    b_prompt = b_valid;
    b_ready = 1'b1;
    n = 0;
    while (!b_valid && n < 20) begin tick; n++; end
    if (!b_valid) tout = 1'b1;
    tick;
    b_ready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, output int lat0,
                          output int gap_bad, output logic tout);
    int n;
    tout = 1'b0; gap_bad = 0; lat0 = 0;
    ar_valid = 1'b1; ar_bits_addr = addr; ar_bits_len = len;
    n = 0;
    while (!ar_ready && n < 20) begin tick; n++; end
    if (!ar_ready) tout = 1'b1;
    tick;
    ar_valid = 1'b0;
    r_ready = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      n = 0;
      while (!r_valid && n < 20) begin tick; n++; end
      if (!r_valid) tout = 1'b1;
      if (i == 0) lat0 = n;
      else if (n != 1) gap_bad++;
      rdata[i] = r_bits_data; rlast[i] = r_bits_last; rid_obs = r_bits_id;
      tick;
    end
    r_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    tick;
    tick;
    n_checks++; if ({aw_ready, ar_ready, w_ready} !== 3'b000) begin n_fail++;
      $display("FAIL reset_ready: got %b expected 000", {aw_ready, ar_ready, w_ready}); end
    n_checks++; if ({b_valid, r_valid, r_bits_last, proto_err} !== 4'b0000) begin n_fail++;
      $display("FAIL reset_valid: got %b expected 0000", {b_valid, r_valid, r_bits_last, proto_err}); end
    n_checks++; if (r_bits_data !== 64'd0) begin n_fail++;
      $display("FAIL reset_rdata: got %h expected 0", r_bits_data); end
    n_checks++; if ({wr_beats, rd_beats} !== 64'd0) begin n_fail++;
      $display("FAIL reset_counters: got %h/%h expected 0/0", wr_beats, rd_beats); end
    reset_n = 1'b1;
    tick;
  endtask

  task automatic test_write_read;
    logic wf, bp, to;
    int lat0, gb;
    for (int i = 0; i < 4; i++) wd[i] = 64'hA0 + 64'(i);
    axi_write(32'h1000_0040, 8'd3, 4, 3, wf, bp, to);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL wr_timeout: got %b expected 0", to); end
    n_checks++; if (wf !== 1'b1) begin n_fail++; $display("FAIL wr_first_wready: got %b expected 1", wf); end
    n_checks++; if (bp !== 1'b1) begin n_fail++; $display("FAIL wr_bvalid_latency: got %b expected 1", bp); end
    n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL wr_proto_err: got %b expected 0", proto_err); end
    axi_read(32'h1000_0040, 8'd3, lat0, gb, to);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL rd_timeout: got %b expected 0", to); end
    n_checks++; if (lat0 !== 1) begin n_fail++; $display("FAIL rd_first_latency: got %0d extra cycles expected 1", lat0); end
    n_checks++; if (gb !== 0) begin n_fail++; $display("FAIL rd_beat_spacing: got %0d bad gaps expected 0", gb); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (rdata[i] !== 64'hA0 + 64'(i)) begin n_fail++;
        $display("FAIL rd_data[%0d]: got %h expected %h", i, rdata[i], 64'hA0 + 64'(i)); end
      n_checks++; if (rlast[i] !== (i == 3)) begin n_fail++;
        $display("FAIL rd_last[%0d]: got %b expected %b", i, rlast[i], (i == 3)); end
    end
    n_checks++; if (rid_obs !== 6'd1) begin n_fail++; $display("FAIL rd_id: got %0d expected 1", rid_obs); end
`ifdef HCPF_SLAVE_BEAT_CNT_EN
    n_checks++; if ({wr_beats, rd_beats} !== {32'd4, 32'd4}) begin n_fail++;
      $display("FAIL beat_counters: got %0d/%0d expected 4/4", wr_beats, rd_beats); end
`else
    n_checks++; if ({wr_beats, rd_beats} !== 64'd0) begin n_fail++;
      $display("FAIL beat_counters_off: got %0d/%0d expected 0/0", wr_beats, rd_beats); end
`endif
  endtask

  task automatic test_wrap;
    logic wf, bp, to;
    int lat0, gb;
    wd[0] = 64'h1111_0000_0000_1111; wd[1] = 64'h2222_0000_0000_2222;
    axi_write(32'h0000_1FF8, 8'd1, 2, 1, wf, bp, to);
    axi_read(32'h0000_0000, 8'd0, lat0, gb, to);
    n_checks++; if (rdata[0] !== 64'h2222_0000_0000_2222) begin n_fail++;
      $display("FAIL wrap_word0: got %h expected 2222000000002222", rdata[0]); end
    axi_read(32'h0000_1FF8, 8'd1, lat0, gb, to);
    n_checks++; if ({rdata[0], rdata[1]} !== {64'h1111_0000_0000_1111, 64'h2222_0000_0000_2222}) begin
      n_fail++; $display("FAIL wrap_read: got %h %h expected 1111000000001111 2222000000002222", rdata[0], rdata[1]); end
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL wrap_timeout: got %b expected 0", to); end
  endtask

  task automatic test_arbitration;
    apply_reset;
    aw_valid = 1'b1; aw_bits_addr = 32'h100; aw_bits_len = 8'd0;
    ar_valid = 1'b1; ar_bits_addr = 32'h100; ar_bits_len = 8'd0;
    tick;
    n_checks++; if ({aw_ready, ar_ready} !== 2'b10) begin n_fail++;
      $display("FAIL arb_first_grant: got aw/ar %b expected 10", {aw_ready, ar_ready}); end
    tick;
    aw_valid = 1'b0;
    w_valid = 1'b1; w_bits_data = 64'h55; w_bits_last = 1'b1;
    n_checks++; if (w_ready !== 1'b1) begin n_fail++; $display("FAIL arb_wready: got %b expected 1", w_ready); end
    tick;
    w_valid = 1'b0; w_bits_last = 1'b0;
    n_checks++; if (b_valid !== 1'b1) begin n_fail++; $display("FAIL arb_bvalid: got %b expected 1", b_valid); end
    b_ready = 1'b1;
    aw_valid = 1'b1; aw_bits_addr = 32'h200;
    tick;
    b_ready = 1'b0;
    n_checks++; if ({aw_ready, ar_ready} !== 2'b01) begin n_fail++;
      $display("FAIL arb_second_grant: got aw/ar %b expected 01", {aw_ready, ar_ready}); end
    tick;
    ar_valid = 1'b0;
    r_ready = 1'b1;
    tick;
    n_checks++; if ({r_valid, r_bits_last, r_bits_data} !== {2'b11, 64'h55}) begin n_fail++;
      $display("FAIL arb_read_beat: got v/l/d %b%b %h expected 11 55", r_valid, r_bits_last, r_bits_data); end
    tick;
    r_ready = 1'b0;
    n_checks++; if (aw_ready !== 1'b1) begin n_fail++;
      $display("FAIL arb_next_aw_ready: got %b expected 1", aw_ready); end
    tick;
    aw_valid = 1'b0;
    w_valid = 1'b1; w_bits_data = 64'h66; w_bits_last = 1'b1;
    tick;
    w_valid = 1'b0; w_bits_last = 1'b0;
    b_ready = 1'b1;
    tick;
    b_ready = 1'b0;
  endtask

  task automatic test_proto_err;
    logic wf, bp, to;
    int lat0, gb;
    apply_reset;
    wd[0] = 64'h71; wd[1] = 64'h72;
    axi_write(32'h300, 8'd0, 2, 1, wf, bp, to);
    n_checks++; if ({bp, proto_err} !== 2'b11) begin n_fail++;
      $display("FAIL perr_late_last: got b/err %b expected 11", {bp, proto_err}); end
    axi_read(32'h300, 8'd1, lat0, gb, to);
    n_checks++; if ({rdata[0], rdata[1]} !== {64'h71, 64'h72}) begin n_fail++;
      $display("FAIL perr_extra_beat: got %h %h expected 71 72", rdata[0], rdata[1]); end
    apply_reset;
    n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL perr_cleared: got %b expected 0", proto_err); end
    wd[0] = 64'h81; wd[1] = 64'h82;
    axi_write(32'h600, 8'd3, 2, 1, wf, bp, to);
    n_checks++; if ({bp, proto_err, to} !== 3'b110) begin n_fail++;
      $display("FAIL perr_early_last: got b/err/to %b expected 110", {bp, proto_err, to}); end
    wd[0] = 64'h91;
    axi_write(32'h700, 8'd0, 1, 0, wf, bp, to);
    n_checks++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL perr_sticky: got %b expected 1", proto_err); end
  endtask

  task automatic test_backpressure_reset;
    logic wf, bp, to;
    logic [63:0] held;
    int lat0, gb, n;
    for (int i = 0; i < 4; i++) wd[i] = 64'hB0 + 64'(i);
    axi_write(32'h400, 8'd3, 4, 3, wf, bp, to);
    ar_valid = 1'b1; ar_bits_addr = 32'h400; ar_bits_len = 8'd3;
    n = 0;
    while (!ar_ready && n < 20) begin tick; n++; end
    tick;
    ar_valid = 1'b0;
    r_ready = 1'b0;
    n = 0;
    while (!r_valid && n < 20) begin tick; n++; end
    held = r_bits_data;
    n_checks++; if (held !== 64'hB0) begin n_fail++; $display("FAIL bp_first_beat: got %h expected b0", held); end
    for (int i = 0; i < 5; i++) begin
      tick;
      n_checks++; if ({r_valid, r_bits_data} !== {1'b1, held}) begin n_fail++;
        $display("FAIL bp_hold[%0d]: got v %b d %h expected 1 %h", i, r_valid, r_bits_data, held); end
    end
    r_ready = 1'b1;
    tick;
    r_ready = 1'b0;
    n = 0;
    while (!r_valid && n < 20) begin tick; n++; end
    n_checks++; if ({r_valid, r_bits_last, r_bits_data} !== {2'b10, 64'hB1}) begin n_fail++;
      $display("FAIL bp_second_beat: got v/l %b%b d %h expected 10 b1", r_valid, r_bits_last, r_bits_data); end
    reset_n = 1'b0;
    #1;
    n_checks++; if ({r_valid, aw_ready, ar_ready} !== 3'b000) begin n_fail++;
      $display("FAIL rst_mid_read: got v/aw/ar %b expected 000", {r_valid, aw_ready, ar_ready}); end
    tick;
    reset_n = 1'b1;
    tick;
    n_checks++; if ({wr_beats, rd_beats} !== 64'd0) begin n_fail++;
      $display("FAIL rst_counters: got %0d/%0d expected 0/0", wr_beats, rd_beats); end
    axi_read(32'h400, 8'd0, lat0, gb, to);
    n_checks++; if ({to, rdata[0]} !== {1'b0, 64'hB0}) begin n_fail++;
      $display("FAIL rst_idle_read: got to %b d %h expected 0 b0", to, rdata[0]); end
    // Abort a write burst after two beats; those beats must survive.
    aw_valid = 1'b1; aw_bits_addr = 32'h500; aw_bits_len = 8'd3;
    n = 0;
    while (!aw_ready && n < 20) begin tick; n++; end
    tick;
    aw_valid = 1'b0;
    w_valid = 1'b1; w_bits_data = 64'hC0; w_bits_last = 1'b0;
    tick;
    w_bits_data = 64'hC1;
    tick;
    w_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    n_checks++; if ({w_ready, b_valid} !== 2'b00) begin n_fail++;
      $display("FAIL rst_mid_write: got wr/b %b expected 00", {w_ready, b_valid}); end
    tick;
    reset_n = 1'b1;
    tick;
    axi_read(32'h500, 8'd1, lat0, gb, to);
    n_checks++; if ({rdata[0], rdata[1]} !== {64'hC0, 64'hC1}) begin n_fail++;
      $display("FAIL rst_mem_kept: got %h %h expected c0 c1", rdata[0], rdata[1]); end
  endtask

  initial begin
    reset_n = 1'b0;
    aw_valid = 1'b0; aw_bits_addr = 32'd0; aw_bits_len = 8'd0;
    w_valid = 1'b0; w_bits_data = 64'd0; w_bits_last = 1'b0;
    b_ready = 1'b0;
    ar_valid = 1'b0; ar_bits_addr = 32'd0; ar_bits_len = 8'd0;
    r_ready = 1'b0;
    test_reset;
    test_write_read;
    test_wrap;
    test_arbitration;
    test_proto_err;
    test_backpressure_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
